// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage array.
package fifo_pkg;

   localparam int unsigned DefaultDataWidth = 8;
   localparam int unsigned DefaultDepth     = 8;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one registered read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DataWidth = DefaultDataWidth,
   parameter int unsigned Depth     = DefaultDepth,
   parameter int unsigned AddrWidth = $clog2(DefaultDepth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [AddrWidth-1:0] raddr_i,
   output logic [DataWidth-1:0] rdata_o
);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [DataWidth-1:0] rdata_q;

   // Storage is intentionally left unreset; only the output register is cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with wrap-bit pointers and registered read data.
module fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned DEPTH      = DefaultDepth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  empty,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   logic [ADDR_WIDTH:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH:0] rptr_q, rptr_d;
   logic                wr_acc;
   logic                rd_acc;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                  (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

   // A read in the same cycle frees the slot, so a write to a full FIFO still proceeds.
   always_comb begin
      rd_acc = re & ~empty;
      wr_acc = we & (~full | rd_acc);
      wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   fifo_mem #(
      .DataWidth (DATA_WIDTH),
      .Depth     (DEPTH),
      .AddrWidth (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_acc),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (data_out)
   );

endmodule

// File: tb/tb_fifo.sv
// Directed stimulus with a queue scoreboard checked by an independent negedge monitor.
module tb_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we  = 1'b0;
   logic       re  = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       empty;
   logic       full;
   logic [7:0] data_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mq[$];     // reference contents
   logic [7:0] exp_q[$];  // expected read results awaiting the monitor
   logic [7:0] m_dout = 8'h00;

   fifo #(
      .DATA_WIDTH (8),
      .DEPTH      (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .re       (re),
      .data_in  (data_in),
      .empty    (empty),
      .full     (full),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares read results, output hold, and flags against the reference.
   always @(negedge clk) begin
      logic [7:0] v;
      if (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         check("read_data", {24'h0, data_out}, {24'h0, v});
      end else begin
         check("data_hold", {24'h0, data_out}, {24'h0, m_dout});
      end
      check("empty_flag", {31'h0, empty}, {31'h0, (mq.size() == 0)});
      check("full_flag", {31'h0, full}, {31'h0, (mq.size() == 8)});
   end

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_dout = 8'h00;
   endtask

   // One clock of stimulus; reference updated just after the edge.
   task automatic op(input logic w, input logic r, input logic [7:0] d);
      logic rd_ok;
      logic wr_ok;
      we = w;
      re = r;
      data_in = d;
      @(posedge clk);
      #1;
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && ((mq.size() < 8) || rd_ok);
      if (rd_ok) begin
         m_dout = mq.pop_front();
         exp_q.push_back(m_dout);
      end
      if (wr_ok) mq.push_back(d);
      we = 1'b0;
      re = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1. Reset then idle
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("reset_empty", {31'h0, empty}, 32'h1);
      check("reset_full", {31'h0, full}, 32'h0);
      check("reset_dout", {24'h0, data_out}, 32'h00);

      // 2. Ordered write/read
      op(1'b1, 1'b0, 8'h44);
      op(1'b1, 1'b0, 8'ha0);
      op(1'b1, 1'b0, 8'hde);
      op(1'b1, 1'b0, 8'had);
      op(1'b0, 1'b1, 8'h00);
      check("first_read", {24'h0, data_out}, 32'h44);
      check("first_read_nonempty", {31'h0, empty}, 32'h0);
      op(1'b1, 1'b0, 8'h00);
      op(1'b1, 1'b0, 8'h10);
      op(1'b1, 1'b0, 8'ha0);
      for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 8'h00);
      check("fourth_read", {24'h0, data_out}, 32'h00);
      op(1'b0, 1'b1, 8'h00);
      op(1'b0, 1'b1, 8'h00);
      check("drain_last", {24'h0, data_out}, 32'ha0);
      check("drain_empty", {31'h0, empty}, 32'h1);

      // 3. Fill to full, overflow ignored, drain
      for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 8'(i));
      check("filled_full", {31'h0, full}, 32'h1);
      op(1'b1, 1'b0, 8'hff);
      check("overflow_full", {31'h0, full}, 32'h1);
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 8'h00);
      check("drain8_dout", {24'h0, data_out}, 32'h08);
      check("drain8_empty", {31'h0, empty}, 32'h1);

      // 4. Underflow
      op(1'b0, 1'b1, 8'h00);
      check("underflow_hold", {24'h0, data_out}, 32'h08);
      check("underflow_empty", {31'h0, empty}, 32'h1);
      op(1'b1, 1'b0, 8'h5a);
      op(1'b0, 1'b1, 8'h00);
      check("after_underflow", {24'h0, data_out}, 32'h5a);

      // 5. Simultaneous ops on full and on empty
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'h11 + 8'(i));
      op(1'b1, 1'b1, 8'h77);
      check("full_rw_dout", {24'h0, data_out}, 32'h11);
      check("full_rw_full", {31'h0, full}, 32'h1);
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 8'h00);
      check("full_rw_last", {24'h0, data_out}, 32'h77);
      op(1'b1, 1'b1, 8'h99);
      check("empty_rw_nonempty", {31'h0, empty}, 32'h0);
      check("empty_rw_nobypass", {24'h0, data_out}, 32'h77);
      op(1'b0, 1'b1, 8'h00);
      check("empty_rw_read", {24'h0, data_out}, 32'h99);

      // 6. Stream across pointer wrap, then asynchronous reset mid-stream
      for (int i = 0; i < 20; i++) op(1'b1, (i >= 2), 8'h30 + 8'(i));
      check("stream_dout", {24'h0, data_out}, 32'h41);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_empty", {31'h0, empty}, 32'h1);
      check("async_rst_full", {31'h0, full}, 32'h0);
      check("async_rst_dout", {24'h0, data_out}, 32'h00);
      @(posedge clk);
      #2;
      rst = 1'b1;
      op(1'b1, 1'b0, 8'hc3);
      op(1'b0, 1'b1, 8'h00);
      check("post_rst_read", {24'h0, data_out}, 32'hc3);
      op(1'b0, 1'b0, 8'h00);
      op(1'b0, 1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
